fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that feeds the microcoded control unit.
//  Holds the PC and runs a req/ack read to instruction memory. Latches the returned word into IR.
//  Presents opcode = IR[15:11] to the control unit's microsequencer.
//  Started by a fetch strobe from a microinstruction signal; PC reloaded by jump micro-ops.
// PARAMETERS
//  PC_WIDTH     10   PC / instruction-memory address width (word addressed)
//  INSTR_WIDTH  16   instruction word width; must be >= 16
//  RESET_PC     0    PC value loaded on reset
//  TIMEOUT      15   max cycles waiting for imem_ack before abort; 1..255
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  fetch_en     in   1            start fetch at current PC (from control-unit signals)
//  pc_wr        in   1            load PC from pc_wr_data
//  pc_wr_data   in   PC_WIDTH     new PC value
//  imem_req     out  1            memory read request
//  imem_addr    out  PC_WIDTH     memory read address
//  imem_ack     in   1            memory data valid; sampled only while imem_req=1
//  imem_rdata   in   INSTR_WIDTH  memory read data; valid when imem_ack=1
//  ir           out  INSTR_WIDTH  instruction register
//  opcode       out  5            ir[15:11], combinational from ir
//  ir_valid     out  1            ir holds a completed fetch
//  fetch_done   out  1            one-cycle pulse: fetch completed this cycle
//  busy         out  1            fetch in progress (state REQ)
//  pc           out  PC_WIDTH     current PC
//  fault        out  1            sticky: a fetch timed out
//  pc_wr_drop   out  1            one-cycle pulse: pc_wr arrived while busy and was ignored
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC; ir=0; ir_valid=0; imem_req=0; imem_addr=0.
//   - busy=0; fault=0; fetch_done=0; pc_wr_drop=0; wait counter=0; state IDLE.
//   - Any in-flight fetch is abandoned; imem_req drops immediately.
//  States: IDLE, REQ.
//  IDLE:
//   - pc_wr=1 alone: pc<=pc_wr_data next edge.
//   - fetch_en=1: imem_addr<=(pc_wr ? pc_wr_data : pc), so a jump bypasses into the same fetch.
//     Also imem_req<=1, ir_valid<=0, counter<=0, state<=REQ. If pc_wr, pc<=pc_wr_data as well.
//   - imem_ack in IDLE is ignored.
//  REQ:
//   - imem_req and imem_addr are held stable until the handshake ends.
//   - imem_ack=1 at an edge: ir<=imem_rdata; pc<=imem_addr+1, wrapping mod 2^PC_WIDTH.
//     Also imem_req<=0, ir_valid<=1, fetch_done pulses 1 cycle, state<=IDLE.
//   - No ack: counter increments. On the edge where counter==TIMEOUT-1 with no ack:
//     imem_req<=0, fault<=1, ir and pc unchanged, ir_valid stays 0, no fetch_done, state<=IDLE.
//   - fetch_en ignored. pc_wr ignored, PC unchanged, pc_wr_drop pulses next cycle.
//  Latency: fetch_en at edge N -> imem_req high after N. Earliest ack sampled at N+1.
//   ir/ir_valid/fetch_done updated after N+1. Minimum 2 cycles, fetch_en to ir_valid.
//  ir_valid stays 1 until the next accepted fetch_en; opcode always reflects ir.
//  fault is cleared only by reset; fetching continues normally afterwards.
//  busy==(state==REQ)==imem_req.
// TESTING
//  1 Reset RESET_PC=0; fetch_en 1 cycle, mem acks next cycle with 16'h3A05
//    -> imem_addr=0, ir=16'h3A05, opcode=5'b00111, pc=1, fetch_done 1 pulse, ir_valid=1.
//  2 Mem ack delayed 5 cycles -> imem_req/imem_addr stable all 5 cycles.
//    busy=1 throughout; ir updates only on ack cycle.
//  3 pc=3FF (PC_WIDTH=10) fetch, ack -> pc wraps to 0.
//    pc_wr=1 with pc_wr_data=0x123 together with fetch_en -> imem_addr=0x123, pc=0x124 after ack.
//  4 No ack for TIMEOUT=15 cycles -> imem_req falls after 15 cycles, fault=1, ir/pc unchanged.
//    Next fetch with ack succeeds; fault stays 1.
//  5 pc_wr and fetch_en pulsed during REQ -> both ignored, pc_wr_drop pulses once, addr unchanged.
//    Stray imem_ack in IDLE -> no state change.
//  6 rst_n low mid-REQ -> imem_req=0 asynchronously, all outputs at reset values.
//    A fetch after release uses RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, runs a req/ack read to instruction
// memory, latches the returned word into IR and presents its opcode field.
module fetch_unit #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   pc_wr,
  input  logic [PC_WIDTH-1:0]    pc_wr_data,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [4:0]             opcode,
  output logic                   ir_valid,
  output logic                   fetch_done,
  output logic                   busy,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   fault,
  output logic                   pc_wr_drop
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
  localparam logic [7:0]          CNT_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   fault_q, fault_d;
  logic                   drop_q, drop_d;
  logic [7:0]             cnt_q, cnt_d;

  // Next-state logic for the IDLE/REQ handshake and all registered outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    drop_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          // A jump issued together with the fetch strobe is used as the fetch address.
          addr_d     = pc_wr ? pc_wr_data : pc_q;
          req_d      = 1'b1;
          ir_valid_d = 1'b0;
          cnt_d      = 8'd0;
          state_d    = REQ;
          if (pc_wr) begin
            pc_d = pc_wr_data;
          end else begin
            pc_d = pc_q;
          end
        end else if (pc_wr) begin
          pc_d = pc_wr_data;
        end else begin
          pc_d = pc_q;
        end
      end
      REQ: begin
        drop_d = pc_wr;
        if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_d       = addr_q + PC_ONE;
          req_d      = 1'b0;
          ir_valid_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_RST;
      addr_q     <= {PC_WIDTH{1'b0}};
      ir_q       <= {INSTR_WIDTH{1'b0}};
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[15:11];
  assign ir_valid   = ir_valid_q;
  assign fetch_done = done_q;
  assign busy       = req_q;
  assign pc         = pc_q;
  assign fault      = fault_q;
  assign pc_wr_drop = drop_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected IR/PC pushed when a fetch is
// launched and popped when fetch_done is observed.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        pc_wr = 1'b0;
  logic [9:0]  pc_wr_data = 10'd0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'd0;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic        ir_valid;
  logic        fetch_done;
  logic        busy;
  logic [9:0]  pc;
  logic        fault;
  logic        pc_wr_drop;

  int checks = 0;
  int failures = 0;

  logic [15:0] q_ir[$];
  logic [9:0]  q_pc[$];
  logic [9:0]  model_pc = 10'd0;
  logic [15:0] model_ir = 16'd0;
  logic        model_fault = 1'b0;

  fetch_unit #(.PC_WIDTH(10), .INSTR_WIDTH(16), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_wr(pc_wr),
    .pc_wr_data(pc_wr_data), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode),
    .ir_valid(ir_valid), .fetch_done(fetch_done), .busy(busy), .pc(pc),
    .fault(fault), .pc_wr_drop(pc_wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one fetch, ack after `delay` wait cycles, optionally poke pc_wr/fetch_en while busy.
  task automatic do_fetch(input logic jump, input logic [9:0] jump_pc, input int delay,
                          input logic [15:0] data, input logic poke);
    logic [9:0] addr;
    logic [15:0] e_ir;
    logic [9:0]  e_pc;
    addr = jump ? jump_pc : model_pc;
    q_ir.push_back(data);
    q_pc.push_back(addr + 10'd1);
    fetch_en = 1'b1;
    pc_wr = jump;
    pc_wr_data = jump_pc;
    tick();
    fetch_en = 1'b0;
    pc_wr = 1'b0;
    check_eq("req_up", {31'd0, imem_req}, 32'd1);
    check_eq("busy_up", {31'd0, busy}, 32'd1);
    check_eq("addr", {22'd0, imem_addr}, {22'd0, addr});
    check_eq("ir_valid_clr", {31'd0, ir_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        fetch_en = 1'b1;
        pc_wr = 1'b1;
        pc_wr_data = 10'h055;
      end
      tick();
      fetch_en = 1'b0;
      pc_wr = 1'b0;
      check_eq("wait_req", {31'd0, imem_req}, 32'd1);
      check_eq("wait_addr", {22'd0, imem_addr}, {22'd0, addr});
      check_eq("wait_ir", {16'd0, ir}, {16'd0, model_ir});
      check_eq("wait_done", {31'd0, fetch_done}, 32'd0);
      check_eq("drop", {31'd0, pc_wr_drop}, {31'd0, (poke && i == 0)});
      if (poke) check_eq("wait_pc", {22'd0, pc}, {22'd0, model_pc});
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    check_eq("fetch_done", {31'd0, fetch_done}, 32'd1);
    if (fetch_done === 1'b1 && q_ir.size() > 0) begin
      e_ir = q_ir.pop_front();
      e_pc = q_pc.pop_front();
      check_eq("ir", {16'd0, ir}, {16'd0, e_ir});
      check_eq("opcode", {27'd0, opcode}, {27'd0, e_ir[15:11]});
      check_eq("pc", {22'd0, pc}, {22'd0, e_pc});
      check_eq("ir_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("req_down", {31'd0, imem_req}, 32'd0);
      check_eq("fault_keep", {31'd0, fault}, {31'd0, model_fault});
      model_ir = e_ir;
      model_pc = e_pc;
    end
    tick();
    check_eq("done_pulse", {31'd0, fetch_done}, 32'd0);
    check_eq("ir_valid_hold", {31'd0, ir_valid}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"}, {22'd0, pc}, 32'd0);
    check_eq({tag, "_ir"}, {16'd0, ir}, 32'd0);
    check_eq({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
    check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check_eq({tag, "_addr"}, {22'd0, imem_addr}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, fetch_done}, 32'd0);
    check_eq({tag, "_drop"}, {31'd0, pc_wr_drop}, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_state("rst");
    rst_n = 1'b1;
    tick();

    // Basic fetch, ack next cycle
    do_fetch(1'b0, 10'd0, 0, 16'h3A05, 1'b0);
    check_eq("opcode_3a05", {27'd0, opcode}, 32'd7);

    // Delayed ack
    do_fetch(1'b0, 10'd0, 5, 16'hF8C1, 1'b0);

    // PC load alone, then wrap at the top of the address space
    pc_wr = 1'b1;
    pc_wr_data = 10'h3FF;
    tick();
    pc_wr = 1'b0;
    check_eq("pc_load", {22'd0, pc}, 32'h3FF);
    check_eq("pc_load_idle", {31'd0, busy}, 32'd0);
    model_pc = 10'h3FF;
    do_fetch(1'b0, 10'd0, 1, 16'h1234, 1'b0);
    check_eq("pc_wrap", {22'd0, pc}, 32'd0);
    do_fetch(1'b1, 10'h123, 2, 16'hA5A5, 1'b0);
    check_eq("jump_pc", {22'd0, pc}, 32'h124);

    // Timeout: no ack for 15 cycles
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      check_eq("tmo_wait_req", {31'd0, imem_req}, 32'd1);
    end
    tick();
    check_eq("tmo_req", {31'd0, imem_req}, 32'd0);
    check_eq("tmo_fault", {31'd0, fault}, 32'd1);
    check_eq("tmo_ir", {16'd0, ir}, {16'd0, model_ir});
    check_eq("tmo_pc", {22'd0, pc}, {22'd0, model_pc});
    check_eq("tmo_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("tmo_done", {31'd0, fetch_done}, 32'd0);
    model_fault = 1'b1;
    do_fetch(1'b0, 10'd0, 0, 16'h5F00, 1'b0);

    // Ignored pc_wr/fetch_en during REQ
    do_fetch(1'b0, 10'd0, 3, 16'h0BAD, 1'b1);

    // Stray ack in IDLE
    imem_ack = 1'b1;
    imem_rdata = 16'hFFFF;
    tick();
    imem_ack = 1'b0;
    check_eq("stray_busy", {31'd0, busy}, 32'd0);
    check_eq("stray_ir", {16'd0, ir}, {16'd0, model_ir});
    check_eq("stray_pc", {22'd0, pc}, {22'd0, model_pc});
    check_eq("stray_done", {31'd0, fetch_done}, 32'd0);

    // Asynchronous reset in the middle of a fetch
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = 10'd0;
    model_ir = 16'd0;
    model_fault = 1'b0;
    tick();
    do_fetch(1'b0, 10'd0, 0, 16'h7777, 1'b0);
    check_eq("post_rst_pc", {22'd0, pc}, 32'd1);
    check_eq("queue_empty", q_ir.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
